// File: rtl/credit_out_buffer_if.sv
// credit_out_buffer_if: bundle of the credit handshake, delay-pipe return,
// downstream handshake and status signals of credit_out_buffer.
// slave  : the buffer itself
// master : the producer/consumer environment driving the buffer
interface credit_out_buffer_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          up_vld;
  logic          up_rdy;
  logic          pipe_vld;
  logic [DW-1:0] pipe_data;
  logic          dn_vld;
  logic          dn_rdy;
  logic [DW-1:0] dn_data;
  logic [CW-1:0] credits;
  logic          ovf_err;

  modport slave (
    input  up_vld, pipe_vld, pipe_data, dn_rdy,
    output up_rdy, dn_vld, dn_data, credits, ovf_err
  );

  modport master (
    output up_vld, pipe_vld, pipe_data, dn_rdy,
    input  up_rdy, dn_vld, dn_data, credits, ovf_err
  );
endinterface

// File: rtl/credit_out_buffer.sv
// credit_out_buffer: credit-gated output buffer behind a fixed-latency,
// non-stallable delay pipe. A producer may only issue into the pipe while a
// credit is free; each result leaving the pipe lands in a DEPTH-entry FIFO and
// its credit is returned when the consumer pops it.
//
// Optional feature (macro CREDIT_OUT_BUFFER_BYPASS_EN): when the FIFO is empty
// a result emerging from the pipe is presented downstream in the same cycle,
// and consumed without a memory write if dn_rdy is high. Without the macro the
// downstream outputs come from registered state only.
module credit_out_buffer #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  credit_out_buffer_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] credits_q, credits_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] mem [DEPTH];

  logic          issue;
  logic          pop;
  logic          push;
  logic          full;
  logic          empty;
  logic          byp_take;
  logic          wr_en;
  logic          rd_en;
  logic          dn_vld_w;
  logic [DW-1:0] dn_data_w;

  // Pointers wrap at DEPTH-1 so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  assign empty = (occ_q == '0);
  assign full  = (occ_q == CW'(DEPTH));

  // Downstream view: bypass presents the pipe result directly when empty.
`ifdef CREDIT_OUT_BUFFER_BYPASS_EN
  assign dn_vld_w  = ~empty | bus.pipe_vld;
  assign dn_data_w = empty ? bus.pipe_data : mem[rd_ptr_q];
  assign byp_take  = empty & bus.pipe_vld & bus.dn_rdy;
`else
  assign dn_vld_w  = ~empty;
  assign dn_data_w = mem[rd_ptr_q];
  assign byp_take  = 1'b0;
`endif

  assign issue = bus.up_vld & bus.up_rdy;
  assign pop   = dn_vld_w & bus.dn_rdy;
  assign push  = bus.pipe_vld;

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign wr_en = push & ~byp_take & (~full | pop);
  assign rd_en = pop & ~byp_take;

  // Next-state for credits, occupancy, pointers and the sticky overflow flag.
  always_comb begin
    credits_d = credits_q;
    occ_d     = occ_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    ovf_d     = ovf_q;

    // Credit return saturates at DEPTH so results pushed without a matching
    // issue (e.g. pipe contents arriving after reset) cannot overshoot.
    if (issue && !pop) begin
      credits_d = credits_q - CW'(1);
    end else if (pop && !issue && credits_q != CW'(DEPTH)) begin
      credits_d = credits_q + CW'(1);
    end

    if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    if (push && full && !pop) ovf_d = 1'b1;
  end

  // Control state register; reset wins over any same-cycle traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= CW'(DEPTH);
      occ_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      occ_q     <= occ_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      ovf_q     <= ovf_d;
    end
  end

  // Data storage, deliberately not reset; contents are only meaningful
  // between wr_ptr and rd_ptr.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr_q] <= bus.pipe_data;
  end

  assign bus.up_rdy  = (credits_q != '0);
  assign bus.credits = credits_q;
  assign bus.dn_vld  = dn_vld_w;
  assign bus.dn_data = dn_data_w;
  assign bus.ovf_err = ovf_q;

endmodule

// File: doc/credit_out_buffer.md
CREDIT_OUT_BUFFER -- requirements
Module: credit_out_buffer

Interface
REQ-001 SHALL have parameter DW, default 8: data width of pipe_data/dn_data.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries and total credits; legal range DEPTH >= 1; full throughput needs DEPTH >= upstream delay + 1.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port up_vld  input  1  producer wants to issue into the fixed-latency delay pipe.
REQ-006 SHALL have port up_rdy  output  1  issue permitted (credit available).
REQ-007 SHALL have port pipe_vld  input  1  result emerging from delay pipe this cycle; cannot be stalled.
REQ-008 SHALL have port pipe_data  input  DW  result data qualified by pipe_vld.
REQ-009 SHALL have port dn_vld  output  1  buffered result available to consumer.
REQ-010 SHALL have port dn_rdy  input  1  consumer accepts dn_data.
REQ-011 SHALL have port dn_data  output  DW  oldest buffered result.
REQ-012 SHALL have port credits  output  $clog2(DEPTH+1)  current free credits.
REQ-013 SHALL have port ovf_err  output  1  sticky overflow flag.

Function
REQ-014 SHALL define issue = up_vld & up_rdy, pop = dn_vld & dn_rdy, push = pipe_vld.
REQ-015 SHALL drive up_rdy = (credits != 0), combinationally from the credit register only; no dependency on up_vld.
REQ-016 SHALL update credits each cycle: issue only -> -1; pop only -> +1; issue and pop together -> unchanged; neither -> unchanged.
REQ-017 SHALL never let credits go below 0 or above DEPTH.
REQ-018 SHALL store each push at wr_ptr in a DEPTH-entry memory and advance wr_ptr; pointers wrap from DEPTH-1 to 0 (DEPTH need not be a power of two).
REQ-019 SHALL hold occupancy count 0..DEPTH; dn_vld = (occupancy != 0); dn_data = mem[rd_ptr]; pop advances rd_ptr.
REQ-020 SHALL, on simultaneous push and pop with occupancy in 1..DEPTH-1, leave occupancy unchanged and perform both.
REQ-021 SHALL, on push while occupancy == DEPTH and no pop the same cycle, drop the data, leave pointers/occupancy unchanged and set ovf_err; push with pop while full is legal.
REQ-022 SHALL keep ovf_err set until rst.
REQ-023 SHALL deliver results in push order; without bypass, a push is visible on dn_vld the following cycle (1-cycle latency).
REQ-024 SHALL ignore dn_rdy while dn_vld = 0 and ignore pipe_data while pipe_vld = 0.

Reset
REQ-025 SHALL, while rst = 1 at posedge clk, set credits = DEPTH, occupancy = 0, rd_ptr = wr_ptr = 0, ovf_err = 0; hence up_rdy = 1, dn_vld = 0.
REQ-026 SHALL give rst priority over issue/push/pop in the same cycle; in-flight pipe results arriving after reset are pushed normally (producer's responsibility to flush the pipe).
REQ-027 SHALL not reset memory contents; dn_data is don't-care while dn_vld = 0.

Configuration
REQ-028 SHALL support macro CREDIT_OUT_BUFFER_BYPASS_EN: when defined and occupancy == 0, dn_vld = pipe_vld and dn_data = pipe_data in the same cycle; if dn_rdy = 1 the result is consumed without a memory write and occupancy stays 0, otherwise it is written normally.
REQ-029 SHALL, without CREDIT_OUT_BUFFER_BYPASS_EN, have dn_vld/dn_data depend only on registered state (no combinational path from pipe_* or dn_rdy).

Verification (DW=8, DEPTH=4, upstream delay 3)
REQ-030 SHALL check reset: rst for 2 cycles -> credits=4, up_rdy=1, dn_vld=0, ovf_err=0.
REQ-031 SHALL check fill: 4 back-to-back issues, dn_rdy=0 -> credits 3,2,1,0, up_rdy=0; pipe returns 0x11,0x22,0x33,0x44 -> then dn_rdy=1 pops 0x11..0x44 in order, credits back to 4.
REQ-032 SHALL check simultaneous: credits=1, occupancy=3, issue and pop same cycle -> credits stays 1, occupancy 2.
REQ-033 SHALL check overflow: occupancy=4, dn_rdy=0, force pipe_vld with 0x99 -> ovf_err=1, dn_data still oldest entry, ovf_err held until rst.
REQ-034 SHALL check bypass: occupancy=0, pipe_vld with 0xA5, dn_rdy=1 -> with macro dn_vld=1 and dn_data=0xA5 same cycle, occupancy 0; without macro dn_vld=1, dn_data=0xA5 next cycle.
REQ-035 SHALL check reset mid-operation: rst asserted with occupancy=2, credits=1 -> next cycle credits=4, dn_vld=0, pointers 0.
